// File: rtl/pipe_flow_ctrl.sv
// rtl/pipe_flow_ctrl.sv - pipeline flow controller: stall, load-use bubbles, redirect flush, interrupt drain
module pipe_flow_ctrl #(
    parameter int N_STAGES         = 5,
    parameter int N_STALL_SRC      = 4,
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int REDIRECT_STAGE   = 3,
    parameter int CNT_W            = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_STALL_SRC-1:0] stall_req,
    input  logic                   load_use_hazard,
    input  logic                   redirect,
    input  logic                   irq_req,
    input  logic                   perf_clr,
    output logic                   pc_en,
    output logic [N_STAGES-2:0]    reg_en,
    output logic [N_STAGES-2:0]    reg_clr,
    output logic                   irq_ack,
    output logic                   busy,
    output logic [CNT_W-1:0]       stall_count
);

    localparam int NREG = N_STAGES - 1;
    localparam int DW   = $clog2(N_STAGES);

    localparam logic [NREG-1:0]  ALL_ONES  = '1;
    // Flush every register upstream of the stage that resolves the redirect.
    localparam logic [NREG-1:0]  REDIR_CLR = ALL_ONES >> (NREG - REDIRECT_STAGE);
    localparam logic [NREG-1:0]  REG0      = NREG'(1);
    localparam logic [NREG-1:0]  REG1      = NREG'(2);
    localparam logic [2:0]       BUB_INIT  = 3'(LOAD_USE_BUBBLES - 2);
    localparam logic [DW-1:0]    DRN_INIT  = DW'(N_STAGES - 2);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_BUBBLE = 2'd1,
        S_DRAIN  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       bub_cnt_q, bub_cnt_d;
    logic [DW-1:0]    drn_cnt_q, drn_cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    // State, bubble/drain down-counters and the performance counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_RUN;
            bub_cnt_q     <= '0;
            drn_cnt_q     <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            bub_cnt_q     <= bub_cnt_d;
            drn_cnt_q     <= drn_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Prioritised next-state and combinational enable/clear generation.
    always_comb begin
        pc_en     = 1'b1;
        reg_en    = ALL_ONES;
        reg_clr   = '0;
        irq_ack   = 1'b0;
        state_d   = state_q;
        bub_cnt_d = bub_cnt_q;
        drn_cnt_d = drn_cnt_q;

        if (|stall_req) begin
            // Full freeze: nothing moves, nothing counts down.
            pc_en  = 1'b0;
            reg_en = '0;
        end else if (redirect) begin
            reg_clr = REDIR_CLR;
            // A redirect cancels pending load-use bubbles; an ongoing drain keeps its place.
            if (state_q == S_BUBBLE) begin
                state_d   = S_RUN;
                bub_cnt_d = '0;
            end
        end else begin
            case (state_q)
                S_DRAIN: begin
                    pc_en   = 1'b0;
                    reg_clr = REG0;
                    if (drn_cnt_q == '0) begin
                        irq_ack = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        drn_cnt_d = drn_cnt_q - 1'b1;
                    end
                end
                S_BUBBLE: begin
                    pc_en   = 1'b0;
                    reg_en  = ~REG0;
                    reg_clr = REG1;
                    if (bub_cnt_q == '0) begin
                        state_d = S_RUN;
                    end else begin
                        bub_cnt_d = bub_cnt_q - 1'b1;
                    end
                end
                default: begin
                    if (irq_req) begin
                        // Stop fetching and let the in-flight instructions retire.
                        pc_en     = 1'b0;
                        reg_clr   = REG0;
                        state_d   = S_DRAIN;
                        drn_cnt_d = DRN_INIT;
                    end else if (load_use_hazard) begin
                        // Detection cycle already counts as the first bubble.
                        pc_en   = 1'b0;
                        reg_en  = ~REG0;
                        reg_clr = REG1;
                        if (LOAD_USE_BUBBLES > 1) begin
                            state_d   = S_BUBBLE;
                            bub_cnt_d = BUB_INIT;
                        end
                    end
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_comb begin
        stall_count_d = stall_count_q;
        if (perf_clr) begin
            stall_count_d = '0;
        end else if (!pc_en && stall_count_q != CNT_MAX) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    assign busy        = (state_q != S_RUN);
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// tb/tb_pipe_flow_ctrl.sv - self-checking bench for pipe_flow_ctrl (two bubble depths)
module tb_pipe_flow_ctrl;

    localparam int NS = 5;
    localparam int RS = 3;

    logic        clk;
    logic        reset_n;
    logic [3:0]  stall_req;
    logic        load_use_hazard;
    logic        redirect;
    logic        irq_req;
    logic        perf_clr;

    logic        pc_en       [2];
    logic [3:0]  reg_en      [2];
    logic [3:0]  reg_clr     [2];
    logic        irq_ack     [2];
    logic        busy        [2];
    logic [15:0] stall_count [2];

    int n_cmp = 0;
    int n_bad = 0;

    pipe_flow_ctrl #(.N_STAGES(NS), .N_STALL_SRC(4), .LOAD_USE_BUBBLES(3),
                     .REDIRECT_STAGE(RS), .CNT_W(16)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .stall_req(stall_req),
        .load_use_hazard(load_use_hazard), .redirect(redirect), .irq_req(irq_req),
        .perf_clr(perf_clr), .pc_en(pc_en[0]), .reg_en(reg_en[0]), .reg_clr(reg_clr[0]),
        .irq_ack(irq_ack[0]), .busy(busy[0]), .stall_count(stall_count[0])
    );

    pipe_flow_ctrl #(.N_STAGES(NS), .N_STALL_SRC(4), .LOAD_USE_BUBBLES(4),
                     .REDIRECT_STAGE(RS), .CNT_W(16)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .stall_req(stall_req),
        .load_use_hazard(load_use_hazard), .redirect(redirect), .irq_req(irq_req),
        .perf_clr(perf_clr), .pc_en(pc_en[1]), .reg_en(reg_en[1]), .reg_clr(reg_clr[1]),
        .irq_ack(irq_ack[1]), .busy(busy[1]), .stall_count(stall_count[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: remaining bubble cycles, remaining drain cycles (ack on the last), stall count.
    int m_bub [2];
    int m_drn [2];
    int m_cnt [2];

    function automatic int bubbles(input int i);
        return (i == 0) ? 3 : 4;
    endfunction

    // 0 stall, 1 redirect, 2 draining, 3 bubbling, 4 irq accept, 5 load-use detect, 6 idle
    function automatic int rule(input int i);
        if (stall_req != 4'b0)  return 0;
        if (redirect)           return 1;
        if (m_drn[i] > 0)       return 2;
        if (m_bub[i] > 0)       return 3;
        if (irq_req)            return 4;
        if (load_use_hazard)    return 5;
        return 6;
    endfunction

    function automatic void expect_out(input int i, output logic pc, output logic [3:0] en,
                                       output logic [3:0] clr, output logic ack, output logic bsy);
        int r;
        r   = rule(i);
        pc  = 1'b1;
        en  = 4'hF;
        clr = 4'h0;
        ack = 1'b0;
        bsy = (m_drn[i] > 0) || (m_bub[i] > 0);
        case (r)
            0: begin pc = 1'b0; en = 4'h0; end
            1: clr = 4'((1 << RS) - 1);
            2, 4: begin pc = 1'b0; clr = 4'b0001; ack = (r == 2) && (m_drn[i] == 1); end
            3, 5: begin pc = 1'b0; en = 4'b1110; clr = 4'b0010; end
            default: ;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model with the inputs that were present during the cycle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                m_bub[i] <= 0;
                m_drn[i] <= 0;
                m_cnt[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic pc, ack, bsy;
                logic [3:0] en, clr;
                expect_out(i, pc, en, clr, ack, bsy);
                if (perf_clr)                  m_cnt[i] <= 0;
                else if (!pc && m_cnt[i] < 65535) m_cnt[i] <= m_cnt[i] + 1;
                case (rule(i))
                    1: m_bub[i] <= 0;
                    2: m_drn[i] <= m_drn[i] - 1;
                    3: m_bub[i] <= m_bub[i] - 1;
                    4: m_drn[i] <= NS - 1;
                    5: m_bub[i] <= bubbles(i) - 1;
                    default: ;
                endcase
            end
        end
    end

    // Every out-of-reset cycle: DUT outputs against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < 2; i++) begin
                logic pc, ack, bsy;
                logic [3:0] en, clr;
                expect_out(i, pc, en, clr, ack, bsy);
                chk($sformatf("model_pc_en[%0d]", i),   32'(pc_en[i]),       32'(pc));
                chk($sformatf("model_reg_en[%0d]", i),  32'(reg_en[i]),      32'(en));
                chk($sformatf("model_reg_clr[%0d]", i), 32'(reg_clr[i]),     32'(clr));
                chk($sformatf("model_irq_ack[%0d]", i), 32'(irq_ack[i]),     32'(ack));
                chk($sformatf("model_busy[%0d]", i),    32'(busy[i]),        32'(bsy));
                chk($sformatf("model_count[%0d]", i),   32'(stall_count[i]), 32'(m_cnt[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n         = 1'b0;
        stall_req       = 4'b0;
        load_use_hazard = 1'b0;
        redirect        = 1'b0;
        irq_req         = 1'b0;
        perf_clr        = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;

        for (int k = 0; k < 5; k++) begin
            #1;
            chk("idle_pc_en",   32'(pc_en[0]),       32'h1);
            chk("idle_reg_en",  32'(reg_en[0]),      32'hF);
            chk("idle_reg_clr", 32'(reg_clr[0]),     32'h0);
            chk("idle_count",   32'(stall_count[0]), 32'h0);
            tick();
        end

        load_use_hazard = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("lu_pc_en",   32'(pc_en[0]),   32'h0);
            chk("lu_reg_clr", 32'(reg_clr[0]), 32'b0010);
            tick();
            load_use_hazard = 1'b0;
        end
        #1;
        chk("lu_run_pc_en", 32'(pc_en[0]),       32'h1);
        chk("lu_run_busy",  32'(busy[0]),        32'h0);
        chk("lu_count3",    32'(stall_count[0]), 32'd3);
        tick();
        #1;
        chk("lu_count4", 32'(stall_count[1]), 32'd4);
        tick();

        irq_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("irq_reg_clr", 32'(reg_clr[0]), 32'b0001);
            chk("irq_ack",     32'(irq_ack[0]), 32'(k == 4));
            tick();
        end
        irq_req = 1'b0;
        #1;
        chk("irq_done_busy", 32'(busy[0]),  32'h0);
        chk("irq_done_pc",   32'(pc_en[0]), 32'h1);
        tick();

        irq_req = 1'b1;
        for (int k = 0; k < 7; k++) begin
            stall_req = (k == 2 || k == 3) ? 4'b0100 : 4'b0000;
            #1;
            chk("irq_stall_ack", 32'(irq_ack[0]), 32'(k == 6));
            if (k != 2 && k != 3) chk("irq_stall_clr", 32'(reg_clr[0]), 32'b0001);
            tick();
        end
        irq_req   = 1'b0;
        stall_req = 4'b0;
        tick();

        redirect        = 1'b1;
        load_use_hazard = 1'b1;
        #1;
        chk("redir_lu_clr", 32'(reg_clr[0]), 32'b0111);
        chk("redir_lu_pc",  32'(pc_en[0]),   32'h1);
        tick();
        redirect        = 1'b0;
        load_use_hazard = 1'b0;
        #1;
        chk("redir_lu_busy", 32'(busy[0]),  32'h0);
        chk("redir_lu_run",  32'(pc_en[0]), 32'h1);
        tick();

        load_use_hazard = 1'b1;
        tick();
        load_use_hazard = 1'b0;
        redirect        = 1'b1;
        #1;
        chk("bub_redir_clr",  32'(reg_clr[1]), 32'b0111);
        chk("bub_redir_pc",   32'(pc_en[1]),   32'h1);
        chk("bub_redir_busy", 32'(busy[1]),    32'h1);
        tick();
        redirect = 1'b0;
        #1;
        chk("bub_after_busy", 32'(busy[1]),  32'h0);
        chk("bub_after_pc",   32'(pc_en[1]), 32'h1);
        tick();

        stall_req = 4'b0001;
        repeat (70000) tick();
        #1;
        chk("sat_count3", 32'(stall_count[0]), 32'hFFFF);
        chk("sat_count4", 32'(stall_count[1]), 32'hFFFF);
        stall_req = 4'b0;
        perf_clr  = 1'b1;
        tick();
        perf_clr = 1'b0;
        #1;
        chk("perf_clr_count", 32'(stall_count[0]), 32'h0);
        tick();

        irq_req = 1'b1;
        tick();
        tick();
        #1;
        chk("mid_drain_busy", 32'(busy[0]), 32'h1);
        reset_n = 1'b0;
        irq_req = 1'b0;
        #1;
        chk("rst_drain_busy", 32'(busy[0]),    32'h0);
        chk("rst_drain_ack",  32'(irq_ack[0]), 32'h0);
        chk("rst_drain_pc",   32'(pc_en[0]),   32'h1);
        tick();
        reset_n = 1'b1;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_flow_ctrl.md
Name: pipe_flow_ctrl

Overview:
Parametrised pipeline flow controller for the in-order RISC-V core. It generates PC enable and per-register enable/clear from external stall sources, load-use hazards, branch/jump redirects and interrupt requests. Unlike the fixed 5-stage controller, it supports configurable depth, multi-bubble load-use stalls, an interrupt drain FSM with acknowledge, and a saturating stall-cycle counter. It sits inside the control unit, next to the hazard handler and forwarding unit.

Parameters:
N_STAGES, 5, pipeline stages (IF..WB); pipeline registers = N_STAGES-1; must be ≥3
N_STALL_SRC, 4, number of external stall request inputs
LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (1..7)
REDIRECT_STAGE, 3, stage index (IF=0) where pc_sel resolves; 1..N_STAGES-1
CNT_W, 16, stall counter width

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
stall_req  in  N_STALL_SRC  external stall sources (memory, atomic, compressed); any bit set freezes the pipeline
load_use_hazard  in  1  ID consumer depends on EXE load
redirect  in  1  pc_sel from REDIRECT_STAGE
irq_req  in  1  level interrupt request, held until irq_ack
perf_clr  in  1  synchronous clear of stall_count
pc_en  out  1  PC register enable
reg_en  out  N_STAGES-1  reg_en[i] enables the register feeding stage i+1
reg_clr  out  N_STAGES-1  synchronous bubble insert for register i
irq_ack  out  1  one-cycle pulse when the pipeline is drained
busy  out  1  state != RUN
stall_count  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- Reset (async, reset_n=0): state=RUN, counters=0. With idle inputs: pc_en=1, reg_en all 1, reg_clr all 0, irq_ack=0, busy=0, stall_count=0.
- Outputs are combinational from state and inputs. State and counters are registered.
- States: RUN, BUBBLE, DRAIN. Down-counter bub_cnt (3b). Down-counter drn_cnt (clog2(N_STAGES)).
- Priority, highest first: any stall_req > redirect > irq_req (RUN only) > load_use_hazard (RUN only).
- Stall: pc_en=0, reg_en=0, reg_clr=0. State and all counters hold. This applies in any state.
- Redirect (no stall): pc_en=1, reg_clr[i]=1 for i<REDIRECT_STAGE, remaining reg_en=1.
  - From BUBBLE: go to RUN; bub_cnt cleared.
  - In DRAIN: state and drn_cnt continue unchanged.
  - A simultaneous irq_req is deferred to the next cycle. A simultaneous load_use_hazard is ignored.
- Load-use in RUN:
  - Detection cycle is bubble 1: pc_en=0, reg_en[0]=0, reg_clr[1]=1, other regs enabled.
  - If LOAD_USE_BUBBLES>1: go to BUBBLE with bub_cnt=LOAD_USE_BUBBLES-2. BUBBLE repeats the same outputs, decrementing bub_cnt; at 0, go to RUN.
  - load_use_hazard is ignored in BUBBLE and DRAIN.
- irq_req in RUN (no stall/redirect): accept cycle T.
  - From T on: pc_en=0, reg_clr[0]=1, other regs enabled.
  - Next state DRAIN with drn_cnt=N_STAGES-2. DRAIN decrements each unstalled cycle.
  - When drn_cnt=0 in DRAIN: irq_ack=1 that cycle, next state RUN.
  - Unstalled ack at T+N_STAGES-1.
  - irq_req arriving in BUBBLE waits until RUN.
- stall_count: +1 each cycle pc_en=0, saturating at all-ones. perf_clr has priority and sets it to 0.
- Reset mid-DRAIN/BUBBLE: immediate return to RUN. No irq_ack issued.

Test Plan:
- Reset then idle 5 cycles → pc_en=1, reg_en=4'b1111, reg_clr=0, stall_count=0.
- LOAD_USE_BUBBLES=3, load_use_hazard pulsed 1 cycle at T → pc_en=0 and reg_clr=4'b0010 at T..T+2, RUN at T+3, stall_count=3.
- irq_req at T (N_STAGES=5) → reg_clr=4'b0001 at T..T+4, irq_ack only at T+4; add stall_req[2] at T+2 for 2 cycles → ack moves to T+6.
- redirect and load_use_hazard at the same cycle → reg_clr=4'b0111, pc_en=1, state stays RUN, no bubble.
- redirect during BUBBLE (LOAD_USE_BUBBLES=4, second cycle) → flush 4'b0111, RUN next cycle, busy=0.
- Force stall_req for 70000 cycles with CNT_W=16 → stall_count=16'hFFFF held; perf_clr → 0 next cycle.
